// File: rtl/string_hw_pkg.sv
// Shared types and constants for the string accelerator sequencer.
package string_hw_pkg;

  typedef enum logic [1:0] {
    OP_LEN  = 2'd0,
    OP_CMP  = 2'd1,
    OP_CPY  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_CAP_A = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEFAULT_MAX_WORDS = 8;
  localparam logic [7:0] NUL_CHAR = 8'h00;

  // Widen a 9-bit two's complement byte difference to a 32-bit result.
  function automatic logic [31:0] sext9(input logic [8:0] d);
    return {{23{d[8]}}, d};
  endfunction

endpackage

// File: rtl/string_op_sequencer_if.sv
// Single shared word port into the StringA/StringB buffers.
interface string_op_sequencer_if
  import string_hw_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
);
  localparam int IW = $clog2(MAX_WORDS);

  logic          buf_sel;
  logic [IW-1:0] buf_idx;
  logic          buf_rd_en;
  logic [31:0]   buf_rdata;
  logic          buf_wr_en;
  logic [31:0]   buf_wdata;

  modport master (
    output buf_sel, buf_idx, buf_rd_en, buf_wr_en, buf_wdata,
    input  buf_rdata
  );

  modport slave (
    input  buf_sel, buf_idx, buf_rd_en, buf_wr_en, buf_wdata,
    output buf_rdata
  );
endinterface

// File: rtl/string_word_scan.sv
// Combinational scan of one 32-bit word: finds the lowest byte that ends the
// operation (NUL in A, or in compare mode also the first A/B byte mismatch).
module string_word_scan
  import string_hw_pkg::*;
(
  input  logic [31:0] a_word,
  input  logic [31:0] b_word,
  input  logic        cmp_mode,
  output logic        stop,
  output logic [1:0]  stop_byte,
  output logic [8:0]  byte_diff
);
  logic [3:0] hit;
  logic [8:0] diff [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      logic [7:0] a_b;
      logic [7:0] b_b;
      assign a_b      = a_word[8*gi +: 8];
      assign b_b      = b_word[8*gi +: 8];
      assign hit[gi]  = (a_b == NUL_CHAR) || (cmp_mode && (a_b != b_b));
      assign diff[gi] = {1'b0, a_b} - {1'b0, b_b};
    end
  endgenerate

  // Walk high-to-low so the lowest hit byte wins.
  always_comb begin
    stop      = |hit;
    stop_byte = 2'd0;
    byte_diff = 9'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) begin
        stop_byte = 2'(i);
        byte_diff = diff[i];
      end
    end
  end
endmodule

// File: rtl/string_op_sequencer.sv
// Runs LEN / CMP / CPY over the string buffers, one word every three cycles.
// Build option: STRSEQ_CPY_EN enables the copy opcode (otherwise op 2 is reserved).
module string_op_sequencer
  import string_hw_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   op,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  result,
  output logic                         error,
  string_op_sequencer_if.master        bus
);
  localparam int IW = $clog2(MAX_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_WORDS - 1);

  state_e        state_reg, state_next;
  op_e           op_reg, op_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [31:0]   a_word_reg, a_word_next;
  logic [31:0]   result_reg, result_next;
  logic          error_reg, error_next;

  logic          rd_en_c;
  logic          sel_c;
  logic [IW-1:0] idx_c;

  logic          scan_stop;
  logic [1:0]    scan_byte;
  logic [8:0]    scan_diff;

  function automatic logic op_supported(input logic [1:0] o);
`ifdef STRSEQ_CPY_EN
    return o != OP_RSVD;
`else
    return (o == OP_LEN) || (o == OP_CMP);
`endif
  endfunction

  // In EVAL the B word requested during CAP_A is on buf_rdata.
  string_word_scan u_scan (
    .a_word    (a_word_reg),
    .b_word    (bus.buf_rdata),
    .cmp_mode  (op_reg == OP_CMP),
    .stop      (scan_stop),
    .stop_byte (scan_byte),
    .byte_diff (scan_diff)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_LEN;
      idx_reg    <= '0;
      a_word_reg <= '0;
      result_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      idx_reg    <= idx_next;
      a_word_reg <= a_word_next;
      result_reg <= result_next;
      error_reg  <= error_next;
    end
  end

`ifdef STRSEQ_CPY_EN
  logic wr_en_c;
  logic wr_en_gated;
`endif

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    idx_next    = idx_reg;
    a_word_next = a_word_reg;
    result_next = result_reg;
    error_next  = error_reg;
    rd_en_c     = 1'b0;
    sel_c       = 1'b0;
    idx_c       = '0;
`ifdef STRSEQ_CPY_EN
    wr_en_c     = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          op_next     = op_e'(op);
          idx_next    = '0;
          result_next = '0;
          error_next  = 1'b0;
          if (op_supported(op)) begin
            state_next = ST_RD_A;
          end else begin
            error_next = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_RD_A: begin
        rd_en_c    = 1'b1;
        idx_c      = idx_reg;
        state_next = ST_CAP_A;
      end
      ST_CAP_A: begin
        a_word_next = bus.buf_rdata;
        if (op_reg == OP_CMP) begin
          rd_en_c = 1'b1;
          sel_c   = 1'b1;
          idx_c   = idx_reg;
        end
        state_next = ST_EVAL;
      end
      ST_EVAL: begin
`ifdef STRSEQ_CPY_EN
        // The whole word is copied, including bytes past the terminator.
        if (op_reg == OP_CPY) begin
          wr_en_c = 1'b1;
          sel_c   = 1'b1;
          idx_c   = idx_reg;
        end
`endif
        if (scan_stop) begin
          result_next = (op_reg == OP_CMP) ? sext9(scan_diff)
                                           : {{(30-IW){1'b0}}, idx_reg, scan_byte};
          state_next  = ST_DONE;
        end else if (idx_reg == LAST_IDX) begin
          error_next  = 1'b1;
          result_next = (op_reg == OP_CMP) ? 32'd0 : 32'(4 * MAX_WORDS);
          state_next  = ST_DONE;
        end else begin
          idx_next   = idx_reg + IW'(1);
          state_next = ST_RD_A;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy   = (state_reg != ST_IDLE);
  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;
  assign error  = error_reg;

  // Buffer strobes are masked during reset so an aborted op never touches memory.
  assign bus.buf_rd_en = rd_en_c & ~reset;
  assign bus.buf_sel   = sel_c;
  assign bus.buf_idx   = idx_c;
`ifdef STRSEQ_CPY_EN
  assign wr_en_gated   = wr_en_c & ~reset;
  assign bus.buf_wr_en = wr_en_gated;
  assign bus.buf_wdata = wr_en_gated ? a_word_reg : 32'd0;
`else
  assign bus.buf_wr_en = 1'b0;
  assign bus.buf_wdata = 32'd0;
`endif
endmodule

// File: tb/tb_string_op_sequencer.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor checks each done pulse.
module tb_string_op_sequencer;
  import string_hw_pkg::*;

  localparam int MAXW = 8;
  localparam int W    = 32 * MAXW;
`ifdef STRSEQ_CPY_EN
  localparam bit CPY_EN = 1'b1;
`else
  localparam bit CPY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_s = 2'd0;
  logic        busy, done, error;
  logic [31:0] result;

  always #5 clk = ~clk;

  string_op_sequencer_if #(.MAX_WORDS(MAXW)) bus ();

  string_op_sequencer #(.MAX_WORDS(MAXW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op_s),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error),
    .bus    (bus)
  );

  typedef struct {
    int          op;
    logic [31:0] result;
    logic        error;
    int          lat;
    int          start_cyc;
    logic [W-1:0] b_after;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cycle_cnt = 0;

  // Buffer model: char i of a string lives at bits [8i+7:8i].
  logic [W-1:0] stage_a = '0, stage_b = '0;
  logic [W-1:0] mem_a = '0, mem_b = '0;
  int           load_gen = 0, seen_gen = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(posedge clk) begin
    if (load_gen != seen_gen) begin
      mem_a = stage_a;
      mem_b = stage_b;
      seen_gen = load_gen;
    end
    if (bus.buf_rd_en)
      bus.buf_rdata <= bus.buf_sel ? mem_b[32*bus.buf_idx +: 32] : mem_a[32*bus.buf_idx +: 32];
    if (bus.buf_wr_en) begin
      if (bus.buf_sel) mem_b[32*bus.buf_idx +: 32] = bus.buf_wdata;
      else             mem_a[32*bus.buf_idx +: 32] = bus.buf_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  exp_t mon_e;
  int   mon_lat;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.buf_wr_en) chk("rd_wr_overlap", 32'(bus.buf_rd_en), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done at cycle %0d with result %h, required no done", cycle_cnt, result);
        end else begin
          mon_e   = sb.pop_front();
          mon_lat = cycle_cnt - mon_e.start_cyc;
          chk("result", result, mon_e.result);
          chk("error", 32'(error), 32'(mon_e.error));
          chk("latency", 32'(mon_lat), 32'(mon_e.lat));
          chk("busy_at_done", 32'(busy), 32'd1);
          n_tests++;
          if (mem_b !== mon_e.b_after) begin
            n_fail++;
            $display("FAIL buf_b: got %h, required %h", mem_b, mon_e.b_after);
          end
          $display("[TB] txn op=%0d start=%0d lat=%0d result=%h error=%0d",
                   mon_e.op, mon_e.start_cyc, mon_lat, result, error);
        end
      end
    end
  end

  // Reference model over character arrays.
  function automatic void model(input int opc, input logic [W-1:0] a, input logic [W-1:0] b,
                                output exp_t e);
    int len, stop, k;
    e.b_after = b;
    e.result  = 32'd0;
    e.error   = 1'b1;
    e.lat     = 1;
    if (opc == 0 || (opc == 2 && CPY_EN)) begin
      len = 4 * MAXW;
      for (int i = 4*MAXW-1; i >= 0; i--) if (a[8*i +: 8] == 8'h00) len = i;
      e.error  = (len == 4 * MAXW);
      e.result = 32'(len);
      k = e.error ? MAXW : len / 4 + 1;
      if (opc == 2) for (int j = 0; j < 4*k; j++) e.b_after[8*j +: 8] = a[8*j +: 8];
      e.lat = 3 * k + 1;
    end else if (opc == 1) begin
      stop = -1;
      for (int i = 4*MAXW-1; i >= 0; i--)
        if (a[8*i +: 8] != b[8*i +: 8] || a[8*i +: 8] == 8'h00) stop = i;
      if (stop < 0) begin
        e.result = 32'd0;
        e.error  = 1'b1;
        e.lat    = 3 * MAXW + 1;
      end else begin
        e.result = 32'(int'(a[8*stop +: 8]) - int'(b[8*stop +: 8]));
        e.error  = 1'b0;
        e.lat    = 3 * (stop / 4 + 1) + 1;
      end
    end
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int w = 0; w < MAXW; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_str(input int len);
    logic [W-1:0] v;
    for (int i = 0; i < 4*MAXW; i++) begin
      if (i < len)       v[8*i +: 8] = 8'($urandom_range(1, 255));
      else if (i == len) v[8*i +: 8] = 8'h00;
      else               v[8*i +: 8] = 8'($urandom);
    end
    return v;
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL done_timeout: %0d ops pending after %0d cycles, required 0", sb.size(), n);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int opc, input logic [W-1:0] a, input logic [W-1:0] b, input bit extra);
    exp_t e;
    stage_a = a;
    stage_b = b;
    load_gen++;
    model(opc, a, b, e);
    e.op = opc;
    e.start_cyc = cycle_cnt;
    sb.push_back(e);
    start = 1'b1;
    op_s  = 2'(opc);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (extra && e.lat > 2) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      op_s  = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_drain();
  endtask

  logic [W-1:0] va, vb;
  int           ropc, rlen, pos;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rd_en", 32'(bus.buf_rd_en), 32'd0);
    chk("rst_wr_en", 32'(bus.buf_wr_en), 32'd0);
    chk("rst_sel", 32'(bus.buf_sel), 32'd0);
    chk("rst_idx", 32'(bus.buf_idx), 32'd0);
    chk("rst_wdata", bus.buf_wdata, 32'd0);
    @(posedge clk);
    #1;

    // Directed cases
    va = rand_vec(); va[31:0] = 32'h00636261;
    issue(0, va, rand_vec(), 1'b0);
    va = rand_vec(); va[31:0] = 32'h64636261; va[63:32] = 32'h00000065;
    issue(0, va, rand_vec(), 1'b0);
    va = rand_vec(); vb = rand_vec(); va[31:0] = 32'h00636261; vb[31:0] = 32'h00646261;
    issue(1, va, vb, 1'b0);
    vb[31:0] = 32'h00636261;
    issue(1, va, vb, 1'b0);
    va = {MAXW{32'h41414141}};
    issue(0, va, rand_vec(), 1'b0);
    va = rand_vec(); va[31:0] = 32'h6C6C6568; va[63:32] = 32'hAA00006F;
    issue(2, va, rand_vec(), 1'b0);

    // Start ignored while busy, then reset mid-operation
    stage_a = {MAXW{32'h41414141}};
    stage_b = rand_vec();
    load_gen++;
    start = 1'b1;
    op_s  = 2'd0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; op_s = 2'd0;
    @(posedge clk); #1; start = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    chk("abort_wr_en", 32'(bus.buf_wr_en), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    issue(3, rand_vec(), rand_vec(), 1'b0);

    // Randomized operations
    for (int t = 0; t < 60; t++) begin
      ropc = $urandom_range(0, 3);
      rlen = $urandom_range(0, 4 * MAXW);
      va = rand_str(rlen);
      vb = rand_vec();
      if (ropc == 1) begin
        case ($urandom_range(0, 2))
          0: vb = va;
          1: begin
            vb  = va;
            pos = $urandom_range(0, 4 * MAXW - 1);
            vb[8*pos +: 8] = 8'($urandom);
          end
          default: vb = rand_str($urandom_range(0, 4 * MAXW));
        endcase
      end
      issue(ropc, va, vb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/string_op_sequencer.md
# string_op_sequencer

Sequencer that runs one string operation (length, compare, copy) over the accelerator's StringA/StringB word buffers. It sits between the Avalon register front end and the buffer storage. The front end pulses `start` with an opcode; the block walks the buffers one 32-bit word at a time through a single shared buffer port, stops at the NUL terminator or at the end of the buffer, then reports `result`/`error` with a one-cycle `done` pulse.

## Interface
- `MAX_WORDS`, 8: words per string buffer (≥2, power of two); buffer capacity is 4*MAX_WORDS chars.
- `IW`, $clog2(MAX_WORDS): word index width (derived, not overridden).
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `op` in 2: 0=LEN(A), 1=CMP(A,B), 2=CPY(A→B), 3=reserved; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted start up to and including the DONE cycle.
- `done` out 1: one-cycle completion pulse.
- `result` out 32: operation result; held until next accepted start.
- `error` out 1: unterminated string or bad opcode; held with `result`.
- `buf_sel` out 1: 0=StringA, 1=StringB.
- `buf_idx` out IW: word index.
- `buf_rd_en` out 1: read request; `buf_rdata` valid the following cycle.
- `buf_rdata` in 32: read data.
- `buf_wr_en` out 1: write strobe (`buf_sel`/`buf_idx`/`buf_wdata` same cycle).
- `buf_wdata` out 32: write data.

## Operation
- Char order: byte 0 (bits 7:0) of word i is char 4i; NUL = 8'h00.
- FSM: IDLE, RD_A, CAP_A, EVAL, DONE.
- IDLE: on `start`, latch op, idx←0, clear result/error; op 0–2 → RD_A; op 3 → DONE with error=1, result=0.
- RD_A: buf_rd_en=1, buf_sel=0, buf_idx=idx → CAP_A.
- CAP_A: latch A word from `buf_rdata`; if CMP, issue read of B[idx] (buf_sel=1) → EVAL.
- EVAL: scan the four bytes low-to-high:
  - LEN: first NUL at byte b → result=4*idx+b, → DONE.
  - CMP: first byte position where A≠B or A==NUL → result = sign-extended (A_byte − B_byte), each byte zero-extended to 9 bits; 0 if stopping on a matching NUL. → DONE.
  - CPY: buf_wr_en=1, buf_sel=1, buf_idx=idx, buf_wdata=A word (whole word, bytes past NUL copied verbatim); NUL at byte b → result=4*idx+b, → DONE.
  - No stop condition and idx<MAX_WORDS−1: idx++ → RD_A.
  - No stop condition at idx=MAX_WORDS−1: error=1; LEN/CPY result=4*MAX_WORDS; CMP result=0. → DONE.
- DONE: done=1 for one cycle → IDLE.
- `start` while not IDLE: ignored, no queueing.
- Reset at any point: IDLE; no buffer write in the reset cycle or after it.
- Reset values: busy=0, done=0, result=0, error=0, buf_rd_en=0, buf_wr_en=0, buf_sel=0, buf_idx=0, buf_wdata=0.

## Timing
- `start` sampled in cycle N (IDLE); k = words processed → `done` high in cycle N+3k+1 for all ops (3 cycles per word).
- Reserved op: `done` high in N+1.
- Next `start` is accepted in cycle N+3k+2 at the earliest, one cycle after the done cycle.
- At most one buffer access (read or write) per cycle; read/write never overlap.
- `result`/`error` valid from the `done` cycle and stable until the next accepted start.

## Configuration
- `STRSEQ_CPY_EN` defined: op 2 performs CPY as above.
- `STRSEQ_CPY_EN` undefined: op 2 handled as reserved (done at N+1, error=1, result=0), and `buf_wr_en`/`buf_wdata` tied to 0.

## Structure
- Package `string_hw_pkg`: op enum (OP_LEN, OP_CMP, OP_CPY, OP_RSVD), FSM state enum, default MAX_WORDS constant, NUL char constant.
- Sub-module `string_word_scan` (combinational): inputs A word, B word, and compare mode. Outputs: stop flag, stop byte index (2 bits), 9-bit signed byte difference.

## Test plan
- LEN, A[0]=32'h00636261 ("abc") → result=3, error=0, done at N+4.
- LEN, A[0]=32'h64636261, A[1]=32'h00000065 → result=5, done at N+7.
- CMP, A[0]=32'h00636261, B[0]=32'h00646261 → result=32'hFFFFFFFF; then B[0]=32'h00636261 → result=0; both done at N+4.
- LEN, all A words 32'h41414141, MAX_WORDS=8 → result=32, error=1, done at N+25.
- CPY, A[0]=32'h6C6C6568, A[1]=32'hAA00006F → B[0..1] written identically, result=5, done at N+7; undefined macro → error=1, B unchanged, done at N+1.
- Start LEN, assert `start` again at N+2 (ignored), then assert reset at N+3 → IDLE, busy=0, no done pulse, no writes; op 3 afterwards → error=1 at N+1.
